// File: rtl/disp_share_ctrl.sv
// disp_share_ctrl: arbitrates the shared 3-digit display between a blinking base source and a timed message source
module disp_share_ctrl #(
  parameter int TICK_DIV    = 5000000,
  parameter int HOLD_TICKS  = 20,
  parameter int GAP_TICKS   = 2,
  parameter int BLINK_TICKS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] base_hex,
  input  logic [2:0]  base_dp,
  input  logic [2:0]  base_en,
  input  logic        blink_en,
  input  logic        msg_req,
  input  logic [14:0] msg_hex,
  input  logic [2:0]  msg_dp,
  input  logic [2:0]  msg_en,
  input  logic        msg_abort,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [4:0]  hex2,
  output logic [4:0]  hex1,
  output logic [4:0]  hex0,
  output logic [2:0]  dp_out,
  output logic [2:0]  en_out
);
  localparam int MAXT = HOLD_TICKS > GAP_TICKS ? (HOLD_TICKS > BLINK_TICKS ? HOLD_TICKS : BLINK_TICKS)
                                               : (GAP_TICKS > BLINK_TICKS ? GAP_TICKS : BLINK_TICKS);
  localparam int TW = MAXT > 1 ? $clog2(MAXT) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [4:0] BLANK = 5'b10010;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] H_MAX = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] G_MAX = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] B_MAX = TW'(BLINK_TICKS - 1);
  typedef enum logic [1:0] {IDLE, MSG, GAP} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic [TW-1:0] tick_cnt;
  logic blink_phase;
  logic [14:0] m_hex;
  logic [2:0] m_dp, m_en;
  logic tick;
  assign tick = presc == P_MAX;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      tick_cnt <= '0;
      blink_phase <= 1'b1;
      m_hex <= '0;
      m_dp <= '0;
      m_en <= '0;
      msg_ack <= 1'b0;
      msg_busy <= 1'b0;
      {hex2, hex1, hex0} <= {3{BLANK}};
      dp_out <= '0;
      en_out <= '0;
    end else begin
      msg_ack <= 1'b0;
      msg_busy <= state != IDLE;
      {hex2, hex1, hex0} <= state == IDLE ? base_hex : state == MSG ? m_hex : {3{BLANK}};
      dp_out <= state == IDLE ? base_dp : state == MSG ? m_dp : 3'b000;
      en_out <= state == IDLE ? (blink_phase ? base_en : 3'b000) : state == MSG ? m_en : 3'b000;
      presc <= tick ? '0 : presc + 1'b1;
      case (state)
        IDLE:
          if (msg_req) begin
            state <= MSG;
            m_hex <= msg_hex;
            m_dp <= msg_dp;
            m_en <= msg_en;
            msg_ack <= 1'b1;
            presc <= '0;
            tick_cnt <= '0;
          end else if (!blink_en) begin
            tick_cnt <= '0;
            blink_phase <= 1'b1;
          end else if (tick) begin
            tick_cnt <= tick_cnt == B_MAX ? '0 : tick_cnt + 1'b1;
            blink_phase <= tick_cnt == B_MAX ? ~blink_phase : blink_phase;
          end
        MSG:
          if (msg_abort || (tick && tick_cnt == H_MAX)) begin
            state <= msg_abort ? IDLE : GAP;
            blink_phase <= 1'b1;
            presc <= '0;
            tick_cnt <= '0;
          end else if (tick) tick_cnt <= tick_cnt + 1'b1;
        GAP:
          if (msg_abort || (tick && tick_cnt == G_MAX)) begin
            state <= IDLE;
            blink_phase <= 1'b1;
            presc <= '0;
            tick_cnt <= '0;
          end else if (tick) tick_cnt <= tick_cnt + 1'b1;
        default: begin
          state <= IDLE;
          presc <= '0;
          tick_cnt <= '0;
        end
      endcase
    end
endmodule

// File: doc/disp_share_ctrl.md
Name: disp_share_ctrl

Overview:
- Arbiter and sequencer for the shared 3-digit seven-segment multiplexer.
- Requester 1 is the base source (stopwatch/counter digits). It is shown continuously and can optionally blink.
- Requester 2 is a message source (e.g. "Uno", "---", overflow text). It is granted the display through a req/ack handshake, held for a fixed time, followed by a blank gap, then the display returns to the base source.
- Outputs feed the multiplexer's hex2/hex1/hex0, dp_in and en_in inputs directly.

Parameters:
- TICK_DIV, 5000000: clock cycles per time tick (prescaler modulus), minimum 2.
- HOLD_TICKS, 20: ticks a granted message stays on display, minimum 1.
- GAP_TICKS, 2: ticks of blank display after a message, minimum 1.
- BLINK_TICKS, 5: ticks per blink half-period of the base source, minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- base_hex  in  15  base digits {hex2,hex1,hex0}, 5-bit codes each
- base_dp  in  3  base decimal points, bit i = digit i
- base_en  in  3  base digit enables
- blink_en  in  1  blink base digits while high
- msg_req  in  1  level request; requester holds it until msg_ack
- msg_hex  in  15  message digits {hex2,hex1,hex0}
- msg_dp  in  3  message decimal points
- msg_en  in  3  message digit enables
- msg_abort  in  1  terminate the active message/gap immediately
- msg_ack  out  1  one-cycle pulse: message accepted and latched
- msg_busy  out  1  high while in MSG or GAP
- hex2, hex1, hex0  out  5 each  digit codes to the multiplexer
- dp_out  out  3  decimal points to the multiplexer
- en_out  out  3  digit enables to the multiplexer

Behaviour:
- All outputs are registered; they reflect the state/inputs of the previous edge (1-cycle latency).
- Reset (asynchronous): state=IDLE, prescaler=0, tick_cnt=0, blink_phase=1, hex2/1/0=5'b10010 (blank code), dp_out=0, en_out=0, msg_ack=0, msg_busy=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the prescaler equals TICK_DIV-1. The prescaler and tick_cnt clear on every state transition.
- IDLE:
  - Outputs = base_hex/base_dp; en_out = base_en when blink_phase=1, else 0.
  - blink_en=1: tick_cnt counts ticks. When tick_cnt==BLINK_TICKS-1 and tick, blink_phase toggles and tick_cnt clears.
  - blink_en=0: blink_phase forced to 1 and tick_cnt held at 0.
  - msg_req=1 sampled: latch msg_hex/dp/en, pulse msg_ack for the next cycle, go to MSG.
- MSG:
  - Outputs = latched message; msg_busy=1. Later changes on msg_* do not affect the display.
  - On tick with tick_cnt==HOLD_TICKS-1, go to GAP.
  - Total MSG duration is exactly HOLD_TICKS*TICK_DIV cycles.
- GAP:
  - en_out=0, dp_out=0, hex=blank code, msg_busy=1.
  - After GAP_TICKS*TICK_DIV cycles, go to IDLE with blink_phase=1.
- msg_req during MSG/GAP: not acknowledged. It is serviced on the first IDLE cycle, so back-to-back messages are separated by at least one IDLE cycle of base display.
- msg_abort: in MSG or GAP, go directly to IDLE next edge; no gap; blink_phase=1. Ignored in IDLE. If msg_abort and msg_req are both high in IDLE, the request is accepted.
- Reset mid-message discards the latched message with no ack. A requester still holding msg_req is accepted on the first cycle after reset release.
- Widths: tick_cnt is wide enough for max(HOLD_TICKS, GAP_TICKS, BLINK_TICKS)-1; the prescaler is clog2(TICK_DIV) bits. No overflow paths.

Test Plan (TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=1, BLINK_TICKS=2):
- Reset asserted mid-run -> all outputs immediately hex=5'b10010, en_out=000, dp_out=000, msg_ack=0. After release, base_hex={5'd1,5'd2,5'd3}, base_en=111 appear one cycle later.
- blink_en=1, base_en=111 -> en_out alternates 111/000 every 8 cycles. blink_en dropped while off -> en_out=111 on the next-but-one edge.
- msg_req with msg_hex={5'b10000,5'b10011,5'b10100} ("Uno") -> msg_ack high exactly 1 cycle. Display shows Uno for 12 cycles, blank for 4 cycles, base restored. msg_busy high for all 16 cycles.
- msg_req held across the whole message, with msg_hex changed during MSG -> displayed value unchanged. Second ack occurs at least 1 IDLE cycle after return, then the new value is shown.
- msg_abort pulsed on cycle 5 of MSG -> base digits shown 1 cycle later, no gap, msg_busy=0.
- msg_req and msg_abort both high in IDLE -> message accepted, msg_ack pulses.
